// File: rtl/mmio_gpio_bank.sv
// Memory-mapped GPIO bank: per-channel output register, synchronised/debounced
// input, sticky rising-edge flags (write-1-to-clear) and per-bit interrupt enable.
module mmio_gpio_bank #(
  parameter logic [15:0] BASE_ADDR = 16'hC000,
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned WIDTH     = 10,
  parameter int unsigned DB_CYCLES = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [15:0]             addr,
  input  logic [15:0]             wdata,
  input  logic                    we,
  input  logic                    re,
  output logic [15:0]             rdata,
  input  logic [NUM_CH*WIDTH-1:0] gpio_in,
  output logic [NUM_CH*WIDTH-1:0] gpio_out,
  output logic                    irq
);

  localparam logic [15:0] WinSize = 16'(4 * NUM_CH);

  typedef enum logic [1:0] {
    RegOut  = 2'd0,
    RegIn   = 2'd1,
    RegEdge = 2'd2,
    RegIen  = 2'd3
  } reg_e;

  logic [15:0] offset;
  logic        mapped;
  logic [1:0]  chan;
  reg_e        reg_sel;

  // Offset wraps for addresses below the base, so one compare covers both ends.
  assign offset  = addr - BASE_ADDR;
  assign mapped  = offset < WinSize;
  assign chan    = offset[3:2];
  assign reg_sel = reg_e'(offset[1:0]);

  logic unused_wdata;
  assign unused_wdata = ^wdata;

  logic [WIDTH-1:0] out_q   [NUM_CH];
  logic [WIDTH-1:0] out_d   [NUM_CH];
  logic [WIDTH-1:0] ien_q   [NUM_CH];
  logic [WIDTH-1:0] ien_d   [NUM_CH];
  logic [WIDTH-1:0] eflag_q [NUM_CH];
  logic [WIDTH-1:0] eflag_d [NUM_CH];
  logic [WIDTH-1:0] sync1_q [NUM_CH];
  logic [WIDTH-1:0] sync1_d [NUM_CH];
  logic [WIDTH-1:0] sync_q  [NUM_CH];
  logic [WIDTH-1:0] sync_d  [NUM_CH];
  logic [WIDTH-1:0] deb_q   [NUM_CH];
  logic [WIDTH-1:0] deb_d   [NUM_CH];
  logic [WIDTH-1:0] debd_q  [NUM_CH];
  logic [WIDTH-1:0] debd_d  [NUM_CH];
  logic [WIDTH-1:0] clr     [NUM_CH];
  logic [WIDTH-1:0] rise    [NUM_CH];
  logic [NUM_CH-1:0] wr_hit;
  logic irq_q, irq_d;

  always_comb begin
    irq_d = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      wr_hit[c]  = we && mapped && (chan == 2'(c));
      out_d[c]   = (wr_hit[c] && reg_sel == RegOut) ? wdata[WIDTH-1:0] : out_q[c];
      ien_d[c]   = (wr_hit[c] && reg_sel == RegIen) ? wdata[WIDTH-1:0] : ien_q[c];
      clr[c]     = (wr_hit[c] && reg_sel == RegEdge) ? wdata[WIDTH-1:0] : '0;
      rise[c]    = deb_q[c] & ~debd_q[c];
      // OR-ing rise after the clear makes a new edge win over a same-cycle W1C.
      eflag_d[c] = (eflag_q[c] & ~clr[c]) | rise[c];
      irq_d      = irq_d | (|(eflag_q[c] & ien_q[c]));
      sync1_d[c] = gpio_in[c*WIDTH +: WIDTH];
      sync_d[c]  = sync1_q[c];
      debd_d[c]  = deb_q[c];
    end
  end

  if (DB_CYCLES == 0) begin : g_nodb
    always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
        deb_d[c] = sync_q[c];
      end
    end
  end else begin : g_db
    localparam int unsigned     CntW   = $clog2(DB_CYCLES + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(DB_CYCLES);

    logic [WIDTH-1:0] sprev_q [NUM_CH];
    logic [WIDTH-1:0] sprev_d [NUM_CH];
    logic [CntW-1:0]  cnt_q   [NUM_CH];
    logic [CntW-1:0]  cnt_d   [NUM_CH];

    always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
        sprev_d[c] = sync_q[c];
        if (sync_q[c] != sprev_q[c]) begin
          cnt_d[c] = '0;
        end else if (cnt_q[c] == CntMax) begin
          cnt_d[c] = cnt_q[c];
        end else begin
          cnt_d[c] = cnt_q[c] + CntW'(1);
        end
        // Require the current sample to agree too, so a change landing on a
        // saturated counter cannot slip through.
        if (cnt_q[c] == CntMax && sync_q[c] == sprev_q[c]) begin
          deb_d[c] = sync_q[c];
        end else begin
          deb_d[c] = deb_q[c];
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int c = 0; c < NUM_CH; c++) begin
          sprev_q[c] <= '0;
          cnt_q[c]   <= '0;
        end
      end else begin
        for (int c = 0; c < NUM_CH; c++) begin
          sprev_q[c] <= sprev_d[c];
          cnt_q[c]   <= cnt_d[c];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        out_q[c]   <= '0;
        ien_q[c]   <= '0;
        eflag_q[c] <= '0;
        sync1_q[c] <= '0;
        sync_q[c]  <= '0;
        deb_q[c]   <= '0;
        debd_q[c]  <= '0;
      end
      irq_q <= 1'b0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        out_q[c]   <= out_d[c];
        ien_q[c]   <= ien_d[c];
        eflag_q[c] <= eflag_d[c];
        sync1_q[c] <= sync1_d[c];
        sync_q[c]  <= sync_d[c];
        deb_q[c]   <= deb_d[c];
        debd_q[c]  <= debd_d[c];
      end
      irq_q <= irq_d;
    end
  end

  always_comb begin
    rdata = '0;
    if (re && mapped) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (chan == 2'(c)) begin
          unique case (reg_sel)
            RegOut:  rdata[WIDTH-1:0] = out_q[c];
            RegIn:   rdata[WIDTH-1:0] = deb_q[c];
            RegEdge: rdata[WIDTH-1:0] = eflag_q[c];
            RegIen:  rdata[WIDTH-1:0] = ien_q[c];
          endcase
        end
      end
    end
  end

  always_comb begin
    gpio_out = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      gpio_out[c*WIDTH +: WIDTH] = out_q[c];
    end
  end

  assign irq = irq_q;

endmodule
